// File: rtl/if_axi_responder_pkg.sv
// Shared definitions for the instruction-fetch to AXI4 read responder.
//   - fetch size codes, AXI response codes, AXI burst codes
//   - responder FSM state encoding
//   - natural-alignment helper used when IF_ALIGN_CHECK_EN is defined
package if_axi_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } if_size_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Every fetch reads one full 8-byte beat.
  localparam logic [2:0] AR_SIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_AR   = 2'b01,
    ST_R    = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] offs, input logic [1:0] size);
    case (if_size_e'(size))
      SIZE_HALF:  return offs[0];
      SIZE_WORD:  return |offs[1:0];
      SIZE_DWORD: return |offs[2:0];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/if_axi_responder_if.sv
// Bundle of the core-side fetch handshake and the AXI4 read channels.
//   master modport : view of the responder (drives AR, consumes R, answers core)
//   slave  modport : view of the surrounding core + AXI slave
interface if_axi_responder_if;
  // Core fetch side
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic [63:0] if_data_read;
  logic [1:0]  if_resp;
  // AXI4 read address channel
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  // AXI4 read data channel
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  modport master (
    input  if_valid, if_addr, if_size,
    output if_ready, if_data_read, if_resp,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready
  );

  modport slave (
    output if_valid, if_addr, if_size,
    input  if_ready, if_data_read, if_resp,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready
  );
endinterface

// File: rtl/if_axi_responder_rdata_align.sv
// if_rdata_align: combinational extraction of the requested item from an
// 8-byte read beat.
//   data    : raw 64-bit beat
//   addr    : byte offset of the request within the beat
//   size    : fetch size code
//   aligned : item shifted to bit 0, upper bits zeroed
// Bytes beyond the end of the beat are shifted in as zero (misaligned
// requests are truncated at the line boundary).
module if_rdata_align
  import if_axi_responder_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  addr,
  input  logic [1:0]  size,
  output logic [63:0] aligned
);

  logic [63:0] shifted;

  assign shifted = data >> {addr, 3'b000};

  always_comb begin
    aligned = '0;
    case (if_size_e'(size))
      SIZE_BYTE:  aligned = {56'd0, shifted[7:0]};
      SIZE_HALF:  aligned = {48'd0, shifted[15:0]};
      SIZE_WORD:  aligned = {32'd0, shifted[31:0]};
      default:    aligned = shifted;
    endcase
  end

endmodule

// File: rtl/if_axi_responder.sv
// if_axi_responder: turns one core fetch request into a single-beat AXI4
// INCR read of the enclosing 8-byte line and returns the requested item.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : if_axi_responder_if.master (fetch handshake + AXI AR/R channels)
// Optional build macro IF_ALIGN_CHECK_EN: misaligned requests complete
// immediately with SLVERR and zero data, without an AXI read.
module if_axi_responder
  import if_axi_responder_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  if_axi_responder_if.master   bus
);

  state_e      state_q, state_d;
  logic [63:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic [63:0] data_q,  data_d;
  logic [1:0]  resp_q,  resp_d;
  logic [63:0] aligned;

  // Only one read is ever outstanding, so the returned ID carries no information.
  logic unused_r_id;
  assign unused_r_id = ^bus.r_id;

  if_rdata_align u_align (
    .data    (bus.r_data),
    .addr    (addr_q[2:0]),
    .size    (size_q),
    .aligned (aligned)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.if_valid) begin
          addr_d = bus.if_addr;
          size_d = bus.if_size;
`ifdef IF_ALIGN_CHECK_EN
          if (is_misaligned(bus.if_addr[2:0], bus.if_size)) begin
            data_d  = '0;
            resp_d  = RESP_SLVERR;
            state_d = ST_DONE;
          end else begin
            state_d = ST_AR;
          end
`else
          state_d = ST_AR;
`endif
        end
      end
      ST_AR: begin
        if (bus.ar_ready) state_d = ST_R;
      end
      ST_R: begin
        // Beats without r_last are accepted and dropped.
        if (bus.r_valid && bus.r_last) begin
          data_d  = aligned;
          resp_d  = bus.r_resp;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  // AR fields derive only from registered state, so they stay stable under backpressure.
  assign bus.ar_valid     = (state_q == ST_AR);
  assign bus.ar_addr      = {addr_q[63:3], 3'b000};
  assign bus.ar_id        = 4'd0;
  assign bus.ar_len       = 8'd0;
  assign bus.ar_size      = AR_SIZE_8B;
  assign bus.ar_burst     = BURST_INCR;
  assign bus.r_ready      = (state_q == ST_R);
  assign bus.if_ready     = (state_q == ST_DONE);
  assign bus.if_data_read = data_q;
  assign bus.if_resp      = resp_q;

endmodule

// File: tb/tb_if_axi_responder.sv
// Self-checking bench for if_axi_responder: table of fetch vectors driven
// through a small AXI slave model, expected results queued at issue time and
// compared when if_ready pulses, plus hand sequences for reset and alignment.
module tb_if_axi_responder;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          ad;
    int          rd;
    bit          extra;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  vec_t vecs[$];
  exp_t sb[$];

  if_axi_responder_if bus ();

  if_axi_responder dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Waits for the completion pulse, checks latency, pops the scoreboard and
  // verifies the pulse is one cycle wide with outputs held afterwards.
  task automatic wait_done(input int start, input int exp_lat);
    bit   seen;
    exp_t e;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.if_ready === 1'b1) seen = 1;
      else tick();
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL if_ready_timeout actual=0 required=1");
    end else begin
      chk("latency", 64'(cyc - start), 64'(exp_lat));
    end
    e.d = 'x;
    e.r = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    chk("if_data_read", bus.if_data_read, e.d);
    chk("if_resp", 64'(bus.if_resp), 64'(e.r));
    tick();
    chk("if_ready_pulse", 64'(bus.if_ready), 64'd0);
    chk("data_hold", bus.if_data_read, e.d);
    chk("resp_hold", 64'(bus.if_resp), 64'(e.r));
  endtask

  task automatic run_txn(input vec_t v);
    exp_t        e;
    int          start;
    int          stab_err;
    logic [63:0] cap;
    e.d = v.exp_data;
    e.r = v.exp_resp;
    sb.push_back(e);
    bus.if_valid = 1'b1;
    bus.if_addr  = v.addr;
    bus.if_size  = v.size;
    start = cyc;
    tick();
    // Change the request inputs after acceptance; the transaction must not notice.
    bus.if_valid = 1'b0;
    bus.if_addr  = ~v.addr;
    bus.if_size  = ~v.size;
    chk("ar_valid", 64'(bus.ar_valid), 64'd1);
    chk("ar_addr", bus.ar_addr, {v.addr[63:3], 3'b000});
    chk("ar_fields", 64'({bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst}),
        64'({4'h0, 8'h00, 3'b011, 2'b01}));
    cap = bus.ar_addr;
    stab_err = 0;
    repeat (v.ad) begin
      bus.ar_ready = 1'b0;
      tick();
      if (bus.ar_valid !== 1'b1 || bus.ar_addr !== cap) stab_err++;
    end
    if (v.ad > 0) chk("ar_stable", 64'(stab_err), 64'd0);
    bus.ar_ready = 1'b1;
    tick();
    bus.ar_ready = 1'b0;
    chk("r_ready", 64'({bus.r_ready, bus.ar_valid}), 64'b10);
    repeat (v.rd) tick();
    if (v.extra) begin
      bus.r_valid = 1'b1;
      bus.r_last  = 1'b0;
      bus.r_data  = 64'hBADB_ADBA_DBAD_BADB;
      bus.r_resp  = 2'b11;
      tick();
    end
    bus.r_valid = 1'b1;
    bus.r_last  = 1'b1;
    bus.r_data  = v.rdata;
    bus.r_resp  = v.rresp;
    bus.r_id    = 4'($urandom_range(0, 15));
    tick();
    bus.r_valid = 1'b0;
    bus.r_last  = 1'b0;
    wait_done(start, 3 + v.ad + v.rd + (v.extra ? 1 : 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_addr  = '0;
    bus.if_size  = '0;
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_data   = '0;
    bus.r_resp   = '0;
    bus.r_last   = 1'b0;
    bus.r_id     = '0;

    //          addr                  size   rdata                   rresp  ad rd extra exp_data                exp_resp
    vecs.push_back('{64'h0000_0000_8000_0000, 2'b11, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 64'h1122_3344_5566_7788, 2'b00});
    vecs.push_back('{64'h0000_0000_8000_0004, 2'b10, 64'hDEAD_BEEF_0000_0013, 2'b00, 0, 0, 0, 64'h0000_0000_DEAD_BEEF, 2'b00});
    vecs.push_back('{64'h0000_0000_8000_0010, 2'b11, 64'hCAFE_BABE_1234_5678, 2'b00, 5, 4, 0, 64'hCAFE_BABE_1234_5678, 2'b00});
    vecs.push_back('{64'h0000_0000_8000_0020, 2'b10, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 0, 0, 64'h0000_0000_89AB_CDEF, 2'b10});
    vecs.push_back('{64'h0000_0000_8000_0003, 2'b00, 64'h1122_3344_5566_7788, 2'b00, 1, 2, 1, 64'h0000_0000_0000_0055, 2'b00});
    vecs.push_back('{64'h0000_0000_8000_0006, 2'b01, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 1, 64'h0000_0000_0000_1122, 2'b00});
    vecs.push_back('{64'h0000_0000_8000_0008, 2'b11, 64'hFFFF_0000_FFFF_0000, 2'b11, 2, 0, 0, 64'hFFFF_0000_FFFF_0000, 2'b11});
`ifndef IF_ALIGN_CHECK_EN
    // Misaligned word: bytes past the end of the line read as zero.
    vecs.push_back('{64'h0000_0000_8000_0005, 2'b10, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 64'h0000_0000_0011_2233, 2'b00});
`endif

    tick();
    tick();
    chk("reset_outputs",
        {bus.if_data_read[63:6], bus.if_data_read[5:0] | {bus.if_ready, bus.ar_valid, bus.r_ready, 1'b0, bus.if_resp}},
        64'd0);
    chk("reset_data", bus.if_data_read, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 64'({bus.if_ready, bus.ar_valid, bus.r_ready}), 64'd0);

    // Consecutive vectors are issued in the IDLE cycle right after DONE.
    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

`ifdef IF_ALIGN_CHECK_EN
    begin
      int start;
      bus.if_valid = 1'b1;
      bus.if_addr  = 64'h0000_0000_8000_0002;
      bus.if_size  = 2'b10;
      start = cyc;
      tick();
      bus.if_valid = 1'b0;
      chk("align_no_ar", 64'(bus.ar_valid), 64'd0);
      chk("align_ready", 64'(bus.if_ready), 64'd1);
      chk("align_resp", 64'(bus.if_resp), 64'h2);
      chk("align_data", bus.if_data_read, 64'd0);
      chk("align_latency", 64'(cyc - start), 64'd1);
      tick();
      chk("align_pulse", 64'({bus.if_ready, bus.ar_valid}), 64'd0);
    end
`endif

    // Reset while waiting for read data: abandon without a completion pulse.
    bus.if_valid = 1'b1;
    bus.if_addr  = 64'h0000_0000_8000_0018;
    bus.if_size  = 2'b11;
    tick();
    bus.if_valid = 1'b0;
    bus.ar_ready = 1'b1;
    tick();
    bus.ar_ready = 1'b0;
    chk("pre_reset_in_r", 64'(bus.r_ready), 64'd1);
    chk("pre_reset_data_nonzero", 64'(bus.if_data_read != 64'd0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({bus.if_ready, bus.ar_valid, bus.r_ready, bus.if_resp}), 64'd0);
    chk("async_reset_data", bus.if_data_read, 64'd0);
    tick();
    chk("no_pulse_in_reset", 64'(bus.if_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_abandon", 64'({bus.if_ready, bus.ar_valid, bus.r_ready}), 64'd0);
    run_txn('{64'h0000_0000_8000_0008, 2'b11, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 0, 0, 0,
              64'h0F0E_0D0C_0B0A_0908, 2'b00});

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_axi_responder.md
IF_AXI_RESPONDER -- requirements
Module: if_axi_responder

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: if_valid  input  1  fetch request from core.
REQ-004 SHALL have port: if_ready  output  1  one-cycle completion pulse to core.
REQ-005 SHALL have port: if_addr  input  64  byte address of request.
REQ-006 SHALL have port: if_size  input  2  00 byte, 01 half, 10 word, 11 dword.
REQ-007 SHALL have port: if_data_read  output  64  read data, requested item right-aligned in bits [LSB].
REQ-008 SHALL have port: if_resp  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-009 SHALL have AXI4 read-master ports: ar_valid out 1, ar_ready in 1, ar_addr out 64, ar_id out 4, ar_len out 8, ar_size out 3, ar_burst out 2.
REQ-010 SHALL have AXI4 read-data ports: r_valid in 1, r_ready out 1, r_data in 64, r_resp in 2, r_last in 1, r_id in 4.

Function
REQ-011 SHALL implement FSM states IDLE, AR, R, DONE.
REQ-012 IDLE: on if_valid=1 SHALL latch if_addr/if_size, go AR next cycle; else stay.
REQ-013 AR: ar_valid=1, ar_addr={latched_addr[63:3],3'b000}, ar_id=0, ar_len=0, ar_size=3'b011, ar_burst=INCR; on ar_ready go R.
REQ-014 ar_addr/ar_* SHALL stay stable while ar_valid=1 and ar_ready=0.
REQ-015 R: r_ready=1; on r_valid&r_last SHALL latch shifted data and r_resp, go DONE; r_valid without r_last SHALL be consumed and ignored.
REQ-016 Data SHALL be r_data >> (latched_addr[2:0]*8), then zero-masked to 8/16/32/64 bits per latched size.
REQ-017 DONE: if_ready=1 for exactly one cycle with if_data_read/if_resp valid; next state IDLE.
REQ-018 if_data_read/if_resp SHALL hold last value outside DONE; if_ready=0 outside DONE.
REQ-019 if_valid high in IDLE right after DONE SHALL start a new transaction with current if_addr (back-to-back fetch).
REQ-020 Minimum latency: if_valid at cycle 0, ar_ready=1 at cycle 1, r_valid=1 at cycle 2 -> if_ready at cycle 3.
REQ-021 Exactly one outstanding AXI transaction; r_id SHALL be ignored.
REQ-022 if_addr/if_size changes after acceptance SHALL not affect the current transaction.

Reset
REQ-023 reset=0 SHALL asynchronously force IDLE; if_ready, ar_valid, r_ready, if_data_read, if_resp, latched addr/size all 0.
REQ-024 Reset mid-transaction SHALL abandon it without completion pulse; the AXI slave is reset in the same domain.

Configuration
REQ-025 Macro IF_ALIGN_CHECK_EN defined: request whose address is not aligned to its size SHALL go IDLE->DONE directly, no AR issued, if_resp=10, if_data_read=0.
REQ-026 Macro undefined: no alignment check; misaligned requests proceed per REQ-013..REQ-016, with the part beyond the 8-byte line truncated.

Structure
REQ-027 Shared package SHALL hold: if_size codes, resp codes (OKAY/EXOKAY/SLVERR/DECERR), AXI burst codes, FSM state encoding.
REQ-028 One sub-module if_rdata_align (combinational shift+mask, inputs data/addr[2:0]/size) SHALL be used; rest flat.

Verification
REQ-029 Dword fetch: addr=0x8000_0000, size=11, slave r_data=0x1122334455667788 OKAY, zero wait -> if_ready at cycle 3, if_data_read=0x1122334455667788, if_resp=00.
REQ-030 Word fetch upper half: addr=0x8000_0004, size=10, r_data=0xDEADBEEF_00000013 -> ar_addr=0x8000_0000, if_data_read=0x00000000DEADBEEF.
REQ-031 Backpressure: ar_ready delayed 5 cycles, r_valid delayed 4 -> ar_* stable throughout, single if_ready pulse, correct data.
REQ-032 Error: r_resp=10 on size=10 fetch -> if_resp=10, if_ready one pulse, FSM back to IDLE.
REQ-033 With IF_ALIGN_CHECK_EN: addr=0x8000_0002, size=10 -> no ar_valid, if_ready at cycle 1, if_resp=10, if_data_read=0.
REQ-034 Reset asserted while in R -> outputs 0 immediately; after release, new fetch at 0x8000_0008 completes normally.
